int_ctrl: RTL

- Interrupt request controller; drives the CPU datapath's interrupt inputs ie1..ie4.
- Synchronizes four external request lines and latches their rising edges as pending.
- Applies a CPU-writable enable mask and issues one one-hot, one-cycle interrupt pulse at a time.
- Holds off further requests until the CPU signals return-from-interrupt (reti, coincident with the stack pop of the return address).

---
 rtl/int_pkg.sv | 31 +++
 rtl/irq_sync_edge.sv | 32 +++
 rtl/int_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared definitions for the interrupt request controller: sizes, FSM
// encoding, IRQ index names and the fixed-priority helpers.
package int_pkg;

    localparam int N_IRQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_SERVICE = 2'b10
    } state_t;

    localparam logic [ID_W-1:0] IRQ_0 = 2'd0;
    localparam logic [ID_W-1:0] IRQ_1 = 2'd1;
    localparam logic [ID_W-1:0] IRQ_2 = 2'd2;
    localparam logic [ID_W-1:0] IRQ_3 = 2'd3;

    // Lowest set index wins, matching the datapath's 4:2 priority encoder.
    function automatic logic [ID_W-1:0] prio_idx(input logic [N_IRQ-1:0] req);
        prio_idx = IRQ_0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (req[k]) prio_idx = ID_W'(k);
        end
    endfunction

    function automatic logic [N_IRQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        return N_IRQ'(1) << id;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One request line: SYNC_STAGES-deep synchronizer followed by a registered
// rising-edge detector. The output is a single-cycle pulse per rising edge.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronize the line, remember the previous synchronized level and
    // register the rising edge. History resets to 0, so a line held high
    // through reset release still produces exactly one edge.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], irq};
            prev_q     <= sync_q[SYNC_STAGES-1];
            edge_pulse <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt request controller. Captures rising edges on four asynchronous
// request lines as pending bits, applies a CPU-writable enable mask and
// issues one registered, one-hot, single-cycle pulse on ie1..ie4 at a time.
// No further interrupt is issued until the CPU signals reti.
module int_ctrl
    import int_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wd,
    input  logic             reti,
    output logic             ie1,
    output logic             ie2,
    output logic             ie3,
    output logic             ie4,
    output logic [N_IRQ-1:0] pending,
    output logic             in_service,
    output logic [ID_W-1:0]  active_id
);

    logic [N_IRQ-1:0] edge_det;
    logic [N_IRQ-1:0] mask_q;
    logic [N_IRQ-1:0] req;
    logic [N_IRQ-1:0] pend_clr;
    logic [N_IRQ-1:0] ie_q;
    logic [N_IRQ-1:0] ie_d;
    logic [ID_W-1:0]  active_id_d;
    logic [ID_W-1:0]  winner;
    logic             in_service_d;
    state_t           state_q;
    state_t           state_d;

    for (genvar k = 0; k < N_IRQ; k++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk       (clk),
            .reset     (reset),
            .irq       (irq_in[k]),
            .edge_pulse(edge_det[k])
        );
    end

    assign req    = pending & mask_q;
    assign winner = prio_idx(req);

    // Enable mask register; the IDLE decision always sees the pre-write value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mask_q <= '0;
        else if (mask_we) mask_q <= mask_wd;
    end

    // Pending bits: a new edge wins over the clear issued at the end of ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= '0;
        else pending <= (pending & ~pend_clr) | edge_det;
    end

    // Next-state and next-output logic for the issue FSM.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        active_id_d  = active_id;
        in_service_d = in_service;
        ie_d         = '0;
        pend_clr     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    active_id_d  = winner;
                    ie_d         = id_onehot(winner);
                    in_service_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pend_clr = id_onehot(active_id);
                state_d  = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (reti) begin
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                in_service_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; all drop asynchronously on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ie_q       <= '0;
            in_service <= 1'b0;
            active_id  <= IRQ_0;
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            in_service <= in_service_d;
            active_id  <= active_id_d;
        end
    end

    assign ie1 = ie_q[0];
    assign ie2 = ie_q[1];
    assign ie3 = ie_q[2];
    assign ie4 = ie_q[3];

endmodule
